// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and
// counter sizing.
package serial_subtractor_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_SHIFT = SHIFT,
        S_DONE  = DONE
    } state_t;

    // Bit counter only needs to reach WIDTH-1; guard the degenerate width.
    function automatic int cnt_width(input int w);
        if (w < 2) begin
            return 1;
        end else begin
            return $clog2(w);
        end
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: diff = x - y - br, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic br,
    output logic diff,
    output logic bo
);

    logic w_xy;

    assign w_xy = x ^ y;
    assign diff = w_xy ^ br;
    assign bo   = (~x & y) | (~w_xy & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor d = a - b - bin, LSB first, with a
// start/busy/done handshake and registered result flags.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic             r_br_msb;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_diff;
    logic             w_bo;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    full_subtractor u_fs (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .br   (r_br),
        .diff (w_diff),
        .bo   (w_bo)
    );

    assign w_last     = (r_state == S_SHIFT) && (r_cnt == CNT_LAST);
    assign w_res_next = {w_diff, r_res[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_SHIFT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_SHIFT;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand shift registers, borrow chain and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_res    <= {WIDTH{1'b0}};
            r_br     <= 1'b0;
            r_br_msb <= 1'b0;
            r_cnt    <= {CW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_br     <= bin;
                        r_res    <= {WIDTH{1'b0}};
                        r_br_msb <= 1'b0;
                        r_cnt    <= {CW{1'b0}};
                    end else begin
                        r_cnt    <= r_cnt;
                    end
                end
                S_SHIFT: begin
                    r_res <= w_res_next;
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_br  <= w_bo;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= r_cnt;
                    end else begin
                        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                    // Borrow into the MSB is kept for the overflow flag.
                    if (r_cnt == CNT_PRE) begin
                        r_br_msb <= w_bo;
                    end else begin
                        r_br_msb <= r_br_msb;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Handshake flags follow the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next_state == S_SHIFT);
            r_done <= (w_next_state == S_DONE);
        end
    end

    // Result registers update only on the final bit, so no partial value leaks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d    <= {WIDTH{1'b0}};
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_last) begin
            r_d    <= w_res_next;
            r_bout <= w_bo;
            r_ovf  <= r_br_msb ^ w_bo;
            r_zero <= (w_res_next == {WIDTH{1'b0}});
        end else begin
            r_d    <= r_d;
            r_bout <= r_bout;
            r_ovf  <= r_ovf;
            r_zero <= r_zero;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign d    = r_d;
    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=3): arithmetic reference
// model with per-cycle compare, plus directed literal checks.
module tb_serial_subtractor;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    logic         zero;

    int n_tests = 0;
    int n_fail  = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic int sgn(input int v);
        return (v >= 4) ? v - 8 : v;
    endfunction

    // Model: m_t = edges since accepted start (-1 = idle).
    int           m_t;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic         m_bin;
    int           e_d;
    int           e_bout;
    int           e_ovf;
    int           e_zero;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t    <= -1;
            e_d    <= 0;
            e_bout <= 0;
            e_ovf  <= 0;
            e_zero <= 0;
        end else if (m_t < 0) begin
            if (start) begin
                m_a   <= a;
                m_b   <= b;
                m_bin <= bin;
                m_t   <= 0;
            end
        end else if (m_t < W - 1) begin
            m_t <= m_t + 1;
        end else if (m_t == W - 1) begin
            m_t    <= W;
            e_d    <= (int'(m_a) - int'(m_b) - int'(m_bin)) & 7;
            e_bout <= (int'(m_a) < int'(m_b) + int'(m_bin)) ? 1 : 0;
            e_ovf  <= ((sgn(int'(m_a)) - sgn(int'(m_b)) - int'(m_bin)) < -4 ||
                       (sgn(int'(m_a)) - sgn(int'(m_b)) - int'(m_bin)) > 3) ? 1 : 0;
            e_zero <= (((int'(m_a) - int'(m_b) - int'(m_bin)) & 7) == 0) ? 1 : 0;
        end else begin
            m_t <= -1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", int'(busy), (m_t >= 0 && m_t < W) ? 1 : 0);
            chk("done", int'(done), (m_t == W) ? 1 : 0);
            chk("d",    int'(d),    e_d);
            chk("bout", int'(bout), e_bout);
            chk("ovf",  int'(ovf),  e_ovf);
            chk("zero", int'(zero), e_zero);
        end
    end

    // One operation; returns result and busy-cycle count observed before done.
    task automatic run_op(input int ia, input int ib, input int ibin,
                          output int rd, output int rbout, output int rovf,
                          output int rzero, output int nbusy);
        int k;
        @(negedge clk);
        a     = W'(ia);
        b     = W'(ib);
        bin   = ibin[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        k = 0;
        while (!done && k < 20) begin
            if (busy) nbusy++;
            @(negedge clk);
            k++;
        end
        if (k >= 20) begin
            chk("done_timeout", 0, 1);
        end
        rd = int'(d); rbout = int'(bout); rovf = int'(ovf); rzero = int'(zero);
    endtask

    task automatic directed(input string name, input int ia, input int ib, input int ibin,
                            input int xd, input int xb, input int xo, input int xz);
        int rd, rb, ro, rz, nb;
        run_op(ia, ib, ibin, rd, rb, ro, rz, nb);
        chk({name, "_d"}, rd, xd);
        chk({name, "_bout"}, rb, xb);
        chk({name, "_ovf"}, ro, xo);
        chk({name, "_zero"}, rz, xz);
        chk({name, "_busycyc"}, nb, W);
    endtask

    int rd, rb, ro, rz, nb;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_d", int'(d), 0);
        chk("rst_flags", int'({bout, ovf, zero}), 0);
        rst = 1'b0;

        directed("s5m3", 5, 3, 0, 2, 0, 1, 0);
        directed("s3m5", 3, 5, 0, 6, 1, 1, 0);
        directed("s4m4b", 4, 4, 1, 7, 1, 0, 0);
        directed("s6m6", 6, 6, 0, 0, 0, 0, 1);

        // Exhaustive sweep, checked by the model every cycle.
        for (int i = 0; i < 128; i++) begin
            run_op(i & 7, (i >> 3) & 7, (i >> 6) & 1, rd, rb, ro, rz, nb);
        end

        // Start held high with operands changing every cycle.
        @(negedge clk);
        a = 3'd5; b = 3'd3; bin = 1'b0; start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == W) begin
                chk("hold_first_d", int'(d), 2);
            end
            a = W'(i + 1); b = W'(6 - (i % 7)); bin = i[0];
        end
        start = 1'b0;
        repeat (8) @(negedge clk);

        // Reset during the second SHIFT cycle aborts the operation.
        run_op(5, 3, 0, rd, rb, ro, rz, nb);
        @(negedge clk);
        a = 3'd7; b = 3'd1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_d", int'(d), 0);
        chk("abort_flags", int'({bout, ovf, zero}), 0);
        @(negedge clk);
        rst = 1'b0;
        directed("after_rst", 7, 1, 0, 6, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing d = a − b − bin, one bit per clock, LSB first. It uses a single registered borrow and one combinational `full_subtractor` cell, so it is the subtraction counterpart of the team's ripple full-adder datapath. The block trades latency for area. It sits beside the lab adders as the reusable subtract unit, with a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 3, operand and result width in bits; legal range ≥ 2.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- a  input  WIDTH  minuend. Captured on the accepted start.
- b  input  WIDTH  subtrahend. Captured on the accepted start.
- bin  input  1  borrow-in. Captured on the accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the results are updated.
- d  output  WIDTH  difference, registered.
- bout  output  1  borrow out of the MSB; high means unsigned a < b + bin.
- ovf  output  1  two's-complement overflow.
- zero  output  1  high when d == 0.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1, load a and b into shift registers and bin into the borrow flop.
  - Clear the bit counter and go to SHIFT.
  - With start=0, stay in IDLE.
- SHIFT, at each edge:
  - Compute the diff bit as x^y^br and the new borrow as (~x&y) | (~(x^y)&br), where x and y are the current LSBs of the operand shift registers.
  - Shift the diff bit into the MSB of the result shift register.
  - Shift both operand registers right and update br.
  - Increment the counter. After the WIDTH-th bit, go to DONE.
- Stage WIDTH−2 → WIDTH−1 transition: store the borrow leaving stage WIDTH−2 (the borrow into the MSB) as br_msb.
- Entry into DONE: load d, bout=br, ovf=br_msb^br and zero=(d==0) into the output registers.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE unconditionally.
  - start is ignored in DONE.
- start is also ignored in SHIFT.
- Outputs d, bout, ovf and zero hold their values from one done to the next done. They never show partial results.
- Arithmetic is modulo 2^WIDTH.
- Inputs a, b and bin may change freely after the accepted start.

## Timing
- Accepted start at edge 0:
  - busy=1 from edge 0 to edge WIDTH.
  - done=1 from edge WIDTH to edge WIDTH+1.
  - The next start is accepted no earlier than edge WIDTH+2.
- Latency from the start sample to done is WIDTH+1 edges. Throughput is one operation per WIDTH+2 cycles.
- busy and done are never high together.
- Reset values: state IDLE; busy=0, done=0, d=0, bout=0, ovf=0, zero=0; counter, shift registers and borrow are cleared.
- Reset asserted mid-operation aborts it immediately (asynchronously). No done is issued. Outputs return to their reset values.
- Reset released with start=1: start is sampled on the first edge after deassertion.

## Structure
- Sub-module `full_subtractor` is one combinational cell with inputs x, y, br and outputs diff, bo. It is instantiated once.
- The shared package holds:
  - the state encoding localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the counter width, $clog2(WIDTH).
- Everything else is local.

## Test plan
All scenarios use WIDTH=3.
- a=5, b=3, bin=0 → after 4 edges: d=2, bout=0, ovf=1, zero=0, with done a single pulse (busy spans 3 cycles).
- a=3, b=5, bin=0 → d=6, bout=1, ovf=1; a=4, b=4, bin=1 → d=7, bout=1, ovf=0, zero=0.
- a=6, b=6, bin=0 → d=0, zero=1, bout=0, ovf=0.
  - Then exhaustively check all 128 (a, b, bin) combinations against a reference model of a − b − bin.
- Hold start=1 continuously with different operands each cycle → only the operands present in IDLE are used. Start is ignored in SHIFT and DONE. Outputs hold between done pulses.
- Assert rst during the second SHIFT cycle → busy=0 and all outputs 0 immediately, with no done pulse. A fresh start afterwards gives the correct result.
